// File: rtl/seg_pkg.sv
// Shared types and glyph helpers for the 7-segment number formatter.
// Glyphs are active-low, bit6..bit0 = segments g..a (DE2 HEX layout).
// Mode 11 is an alias of hex so that any mode with bit 1 set selects hex.
package seg_pkg;

  typedef enum logic [1:0] {
    FM_UDEC = 2'b00,
    FM_SDEC = 2'b01,
    FM_HEX  = 2'b10,
    FM_HEX2 = 2'b11
  } fmt_mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_FMT  = 2'd2
  } fmt_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Active-low glyph for one hex nibble (0-9, A b C d E F).
  function automatic logic [6:0] seg7_hex_al(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_bcd_core.sv
// Double-dabble binary-to-BCD engine: one input bit per cycle, WIDTH cycles per conversion.
// Latency: start edge loads the operand, o_done is high during the last of WIDTH shift cycles.
// No backpressure: i_start is only honoured by the caller while idle; o_bcd holds until next start.
module seg_bcd_core #(
  parameter int WIDTH = 32,
  parameter int BCDD  = 10
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_bin,
  output logic               o_busy,
  output logic               o_done,
  output logic [BCDD*4-1:0]  o_bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]  r_bin;
  logic [BCDD*4-1:0] r_bcd;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;
  logic [BCDD*4-1:0] w_adj;

  // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < BCDD; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
  end

  // Load on start, then shift one binary bit into the BCD register per cycle.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_bin  <= i_bin;
      r_bcd  <= '0;
      r_cnt  <= CW'(WIDTH);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_bcd  <= {w_adj[BCDD*4-2:0], r_bin[WIDTH-1]};
      r_bin  <= {r_bin[WIDTH-2:0], 1'b0};
      r_cnt  <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == CW'(1));
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/seg_num_fmt.sv
// Number-to-7-segment formatter: unsigned/signed decimal or hex value into NDIG active-low glyphs.
// Latency accept->o_done: decimal WIDTH+2 cycles, hex 2 cycles; outputs hold until next o_done.
// o_ready is low while busy; requests presented while busy are dropped, not queued.
module seg_num_fmt
  import seg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NDIG  = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [WIDTH-1:0]  i_bin,
  input  logic [1:0]        i_mode,
  input  logic              i_zs,
  output logic [7*NDIG-1:0] o_seg,
  output logic              o_done,
  output logic              o_ovf,
  output logic              o_neg
);

  localparam int BCDD = (WIDTH * 302) / 1000 + 1;
  localparam int HEXD = (WIDTH + 3) / 4;
  localparam int SRCD = (BCDD > HEXD) ? BCDD : HEXD;
  // Digit source is padded so every displayed position has a nibble (zero when beyond the value).
  localparam int TOTD = (SRCD > NDIG) ? SRCD : NDIG;
  localparam int TW   = TOTD * 4;

  fmt_state_t        r_state;
  logic [WIDTH-1:0]  r_mag;
  logic              r_neg, r_zs, r_hex, r_ready, r_done, r_ovf, r_neg_o;
  logic [7*NDIG-1:0] r_seg;

  fmt_mode_t         w_mode;
  logic              w_accept, w_sneg, w_core_start, w_core_busy, w_core_done;
  logic [WIDTH-1:0]  w_mag;
  logic [BCDD*4-1:0] w_bcd;
  logic [TW-1:0]     w_src;
  logic [7:0]        w_sig, w_mpos;
  logic              w_ovf;
  logic [7*NDIG-1:0] w_seg;

  assign w_mode       = fmt_mode_t'(i_mode);
  assign w_accept     = i_valid && r_ready;
  // Two's-complement negation gives the correct magnitude even for the most negative value.
  assign w_sneg       = (w_mode == FM_SDEC) && i_bin[WIDTH-1];
  assign w_mag        = w_sneg ? -i_bin : i_bin;
  assign w_core_start = w_accept && !i_mode[1];

  seg_bcd_core #(.WIDTH(WIDTH), .BCDD(BCDD)) u_core (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_start (w_core_start),
    .i_bin   (w_mag),
    .o_busy  (w_core_busy),
    .o_done  (w_core_done),
    .o_bcd   (w_bcd)
  );

  // Significant digit count: index of highest nonzero nibble plus one, 1 for a zero value.
  always_comb begin
    w_src = r_hex ? TW'(r_mag) : TW'(w_bcd);
    w_sig = 8'd1;
    for (int i = 0; i < TOTD; i++) begin
      if (w_src[i*4 +: 4] != 4'd0) w_sig = 8'(i + 1);
    end
  end

  // A negative result needs one spare position for the minus sign.
  assign w_ovf  = (w_sig > 8'(NDIG)) || (r_neg && (w_sig >= 8'(NDIG)));
  assign w_mpos = r_zs ? w_sig : 8'(NDIG - 1);

  // Glyph placement: dashes on overflow, minus sign, digits, blanked leading zeros.
  always_comb begin
    w_seg = '1;
    for (int j = 0; j < NDIG; j++) begin
      if (w_ovf)                         w_seg[j*7 +: 7] = SEG_MINUS;
      else if (r_neg && 8'(j) == w_mpos) w_seg[j*7 +: 7] = SEG_MINUS;
      else if (!r_zs || 8'(j) < w_sig)   w_seg[j*7 +: 7] = seg7_hex_al(w_src[j*4 +: 4]);
      else                               w_seg[j*7 +: 7] = SEG_BLANK;
    end
  end

  // Handshake FSM: capture request, wait for the BCD core in decimal modes, register the result.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= S_IDLE;
      r_mag   <= '0;
      r_neg   <= 1'b0;
      r_zs    <= 1'b0;
      r_hex   <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_neg_o <= 1'b0;
      r_seg   <= '1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mag   <= w_mag;
            r_neg   <= w_sneg;
            r_zs    <= i_zs;
            r_hex   <= i_mode[1];
            r_ready <= 1'b0;
            r_state <= i_mode[1] ? S_FMT : S_CONV;
          end
        end
        S_CONV: begin
          // The idle check only matters if the core were ever stopped without a done pulse.
          if (w_core_done || !w_core_busy) r_state <= S_FMT;
        end
        S_FMT: begin
          r_seg   <= w_seg;
          r_ovf   <= w_ovf;
          r_neg_o <= r_neg;
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_seg   = r_seg;
  assign o_done  = r_done;
  assign o_ovf   = r_ovf;
  assign o_neg   = r_neg_o;

endmodule

// File: tb/tb_seg_num_fmt.sv
// Bench for seg_num_fmt (WIDTH=32, NDIG=8): directed spec cases plus random requests,
// each result compared with a reference computed by repeated division of the value.
module tb_seg_num_fmt;

  localparam int WIDTH = 32;
  localparam int NDIG  = 8;
  localparam int DEC_LAT = WIDTH + 2;
  localparam int HEX_LAT = 2;

  logic        i_clk = 1'b0;
  logic        i_rstn, i_valid, i_zs;
  logic        o_ready, o_done, o_ovf, o_neg;
  logic [31:0] i_bin;
  logic [1:0]  i_mode;
  logic [55:0] o_seg;

  int n_chk = 0;
  int n_err = 0;
  logic [6:0] gly [16];
  localparam logic [6:0] G_BLANK = 7'h7F;
  localparam logic [6:0] G_MINUS = 7'b0111111;

  always #5 i_clk = ~i_clk;

  seg_num_fmt #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_bin   (i_bin),
    .i_mode  (i_mode),
    .i_zs    (i_zs),
    .o_seg   (o_seg),
    .o_done  (o_done),
    .o_ovf   (o_ovf),
    .o_neg   (o_neg)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: split the magnitude into base-10/16 digits by division, then place glyphs.
  function automatic void model(input logic [31:0] b, input logic [1:0] m, input logic zs,
                                output logic [55:0] seg, output logic ovf, output logic neg);
    longint unsigned v, base;
    int dig [16];
    int s, mpos;
    neg  = (m == 2'b01) && b[31];
    v    = neg ? (64'h1_0000_0000 - {32'b0, b}) : {32'b0, b};
    base = m[1] ? 16 : 10;
    s    = 1;
    for (int i = 0; i < 16; i++) begin
      dig[i] = int'(v % base);
      v      = v / base;
      if (dig[i] != 0) s = i + 1;
    end
    ovf  = neg ? (s > NDIG - 1) : (s > NDIG);
    mpos = zs ? s : NDIG - 1;
    for (int j = 0; j < NDIG; j++) begin
      if (ovf)                  seg[j*7 +: 7] = G_MINUS;
      else if (neg && j == mpos) seg[j*7 +: 7] = G_MINUS;
      else if (!zs || j < s)    seg[j*7 +: 7] = gly[dig[j]];
      else                      seg[j*7 +: 7] = G_BLANK;
    end
  endfunction

  // Issue one request; optionally pulse a second request inj_at cycles later (must be ignored).
  task automatic do_req(input logic [31:0] b, input logic [1:0] m, input logic zs,
                        input int inj_at, input logic [31:0] inj_bin, output int lat);
    int w = 0;
    while (!o_ready && w < 200) begin
      @(negedge i_clk);
      w++;
    end
    i_valid = 1'b1; i_bin = b; i_mode = m; i_zs = zs;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    lat = 1;
    while (!o_done && lat < 200) begin
      if (lat == inj_at) begin
        chk("ready_busy", {63'b0, o_ready}, 64'd0);
        i_valid = 1'b1; i_bin = inj_bin; i_mode = 2'b10; i_zs = ~zs;
      end
      @(posedge i_clk);
      lat++;
      @(negedge i_clk);
      i_valid = 1'b0;
    end
  endtask

  task automatic check_req(input string tag, input logic [31:0] b, input logic [1:0] m,
                           input logic zs, input int inj_at);
    logic [55:0] eseg;
    logic        eovf, eneg;
    int          lat;
    do_req(b, m, zs, inj_at, 32'd999, lat);
    model(b, m, zs, eseg, eovf, eneg);
    chk({tag, "_lat"}, 64'(lat), m[1] ? 64'(HEX_LAT) : 64'(DEC_LAT));
    chk({tag, "_seg"}, {8'b0, o_seg}, {8'b0, eseg});
    chk({tag, "_ovf"}, {63'b0, o_ovf}, {63'b0, eovf});
    chk({tag, "_neg"}, {63'b0, o_neg}, {63'b0, eneg});
  endtask

  initial begin
    logic [31:0] rb;
    gly = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    i_rstn = 1'b0; i_valid = 1'b0; i_bin = '0; i_mode = '0; i_zs = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_seg",   {8'b0, o_seg}, {8'b0, {56{1'b1}}});
    chk("rst_ready", {63'b0, o_ready}, 64'd1);
    chk("rst_done",  {63'b0, o_done}, 64'd0);
    chk("rst_ovf",   {63'b0, o_ovf}, 64'd0);
    chk("rst_neg",   {63'b0, o_neg}, 64'd0);
    i_rstn = 1'b1;
    @(negedge i_clk);

    // Directed cases from the spec, including a hand-written glyph string for 1234.
    check_req("u1234", 32'd1234, 2'b00, 1'b1, 0);
    chk("u1234_lit", {8'b0, o_seg},
        {8'b0, G_BLANK, G_BLANK, G_BLANK, G_BLANK, 7'h79, 7'h24, 7'h30, 7'h19});
    @(negedge i_clk);
    chk("done_pulse", {63'b0, o_done}, 64'd0);
    chk("hold_seg", {8'b0, o_seg[27:0]}, {36'b0, 7'h79, 7'h24, 7'h30, 7'h19});
    check_req("sm5_zs1", 32'hFFFF_FFFB, 2'b01, 1'b1, 0);
    check_req("sm5_zs0", 32'hFFFF_FFFB, 2'b01, 1'b0, 0);
    check_req("deadbeef", 32'hDEAD_BEEF, 2'b10, 1'b0, 0);
    chk("deadbeef_lit", {8'b0, o_seg},
        {8'b0, 7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E});
    check_req("hex2_zs1", 32'h0000_0A5, 2'b11, 1'b1, 0);
    check_req("u1e8", 32'd100000000, 2'b00, 1'b1, 0);
    check_req("u99999999", 32'd99999999, 2'b00, 1'b1, 0);
    check_req("s_min", 32'h8000_0000, 2'b01, 1'b1, 0);
    check_req("s_m9999999", -32'sd9999999, 2'b01, 1'b0, 0);
    check_req("s_m10000000", -32'sd10000000, 2'b01, 1'b1, 0);
    check_req("s_zero", 32'd0, 2'b01, 1'b1, 0);
    check_req("u_max", 32'hFFFF_FFFF, 2'b00, 1'b0, 0);
    check_req("hex_max", 32'hFFFF_FFFF, 2'b10, 1'b1, 0);
    check_req("ignore_busy", 32'd1234, 2'b00, 1'b1, 5);
    check_req("s_min_again", 32'h8000_0000, 2'b01, 1'b0, 0);

    // Reset in the middle of a conversion: immediate reset values, no done pulse.
    i_valid = 1'b1; i_bin = 32'd4321; i_mode = 2'b00; i_zs = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (10) @(negedge i_clk);
    i_rstn = 1'b0;
    #1;
    chk("mid_rst_seg",   {8'b0, o_seg}, {8'b0, {56{1'b1}}});
    chk("mid_rst_ready", {63'b0, o_ready}, 64'd1);
    chk("mid_rst_ovf",   {63'b0, o_ovf}, 64'd0);
    chk("mid_rst_neg",   {63'b0, o_neg}, 64'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      chk("mid_rst_nodone", {63'b0, o_done}, 64'd0);
    end
    check_req("after_rst", 32'd4321, 2'b00, 1'b0, 0);

    // Random requests, magnitudes spread over many decades.
    for (int n = 0; n < 60; n++) begin
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rb = -rb;
      check_req("rand", rb, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
